// File: rtl/deinterleaver.sv
// Block de-interleaver: 4 x RS(255) frames, ping-pong RAM, linear readout.
// Ports: clk_out125M/sys_rst_n; in_data/in_valid in; out_data/valid/sof/eof, bank_full out.
module deinterleaver #(
  parameter int SYM_W  = 8,
  parameter int CW_LEN = 255,
  parameter int DEPTH  = 4
) (
  input  logic             clk_out125M,
  input  logic             sys_rst_n,
  input  logic [SYM_W-1:0] in_data,
  input  logic             in_valid,
  output logic [SYM_W-1:0] out_data,
  output logic             out_valid,
  output logic             out_sof,
  output logic             out_eof,
  output logic [1:0]       bank_full
);

  localparam int FRAME = CW_LEN * DEPTH;
  localparam int AW    = 10;
  localparam logic [AW-1:0] LAST = AW'(FRAME - 1);

  typedef enum logic {
    RD_IDLE,
    RD_ACTIVE
  } rd_state_t;

  // write side: digit counters and partial sums
  logic [1:0]    c1, c2;
  logic [2:0]    c3;
  logic [4:0]    c4;
  logic [AW-1:0] p1, p2, p3;
  logic [AW-1:0] wr_addr;
  logic          wr_bank;
  logic          wr_last;

  logic [SYM_W-1:0] mem [0:2047];
  logic [SYM_W-1:0] ram_q;

  // read side
  rd_state_t     state, state_n;
  logic [AW-1:0] r, r_n;
  logic          rd_bank, rd_bank_n;
  logic          rd_en;
  logic [1:0]    set_mask, clr_mask, full_la;

  logic             rd_v1, rd_sof1, rd_eof1;
  logic             rt_v, rt_sof, rt_eof;
  logic [SYM_W-1:0] rt_data;

  assign wr_addr = p1 + p2 + p3 + AW'(c4);
  assign wr_last = (c1 == 2'd3) && (c2 == 2'd2)
                && (c3 == 3'd4) && (c4 == 5'd16);

  always_ff @(posedge clk_out125M or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      c1      <= '0;
      c2      <= '0;
      c3      <= '0;
      c4      <= '0;
      p1      <= '0;
      p2      <= '0;
      p3      <= '0;
      wr_bank <= 1'b0;
    end else if (in_valid) begin
      if (c1 == 2'd3) begin
        c1 <= '0;
        p1 <= '0;
        if (c2 == 2'd2) begin
          c2 <= '0;
          p2 <= '0;
          if (c3 == 3'd4) begin
            c3 <= '0;
            p3 <= '0;
            if (c4 == 5'd16) c4 <= '0;
            else             c4 <= c4 + 5'd1;
          end else begin
            c3 <= c3 + 3'd1;
            p3 <= p3 + 10'd17;
          end
        end else begin
          c2 <= c2 + 2'd1;
          p2 <= p2 + 10'd85;
        end
      end else begin
        c1 <= c1 + 2'd1;
        p1 <= p1 + 10'd255;
      end
      if (wr_last) wr_bank <= ~wr_bank;
    end
  end

  // plain RAM, no reset: stale contents are never read
  // because bank_full gates every readout
  always_ff @(posedge clk_out125M) begin
    if (in_valid) mem[{wr_bank, wr_addr}] <= in_data;
    if (rd_en)    ram_q <= mem[{rd_bank, r}];
  end

  always_comb begin
    set_mask = '0;
    if (in_valid && wr_last) set_mask[wr_bank] = 1'b1;
  end

  // a bank completing on this edge counts as full, so the
  // reader starts (or chains) without waiting a cycle
  assign full_la = bank_full | set_mask;

  always_comb begin
    state_n   = state;
    r_n       = r;
    rd_bank_n = rd_bank;
    clr_mask  = '0;
    rd_en     = 1'b0;
    unique case (state)
      RD_IDLE: begin
        if (full_la[rd_bank]) begin
          state_n = RD_ACTIVE;
          r_n     = '0;
        end
      end
      RD_ACTIVE: begin
        rd_en = 1'b1;
        if (r == LAST) begin
          clr_mask[rd_bank] = 1'b1;
          rd_bank_n         = ~rd_bank;
          r_n               = '0;
          if (!full_la[~rd_bank]) state_n = RD_IDLE;
        end else begin
          r_n = r + 10'd1;
        end
      end
      default: state_n = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk_out125M or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= RD_IDLE;
      r         <= '0;
      rd_bank   <= 1'b0;
      bank_full <= '0;
    end else begin
      state     <= state_n;
      r         <= r_n;
      rd_bank   <= rd_bank_n;
      bank_full <= (bank_full | set_mask) & ~clr_mask;
    end
  end

  // RAM read, retiming register, output register:
  // first output lands 3 edges after the frame completes
  always_ff @(posedge clk_out125M or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rd_v1     <= 1'b0;
      rd_sof1   <= 1'b0;
      rd_eof1   <= 1'b0;
      rt_v      <= 1'b0;
      rt_sof    <= 1'b0;
      rt_eof    <= 1'b0;
      rt_data   <= '0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      out_data  <= '0;
    end else begin
      rd_v1     <= rd_en;
      rd_sof1   <= rd_en && (r == '0);
      rd_eof1   <= rd_en && (r == LAST);
      rt_v      <= rd_v1;
      rt_sof    <= rd_sof1;
      rt_eof    <= rd_eof1;
      rt_data   <= rd_v1 ? ram_q : '0;
      out_valid <= rt_v;
      out_sof   <= rt_sof;
      out_eof   <= rt_eof;
      out_data  <= rt_v ? rt_data : '0;
    end
  end

endmodule

// File: tb/tb_deinterleaver.sv
// Directed bench for deinterleaver: map, latency,
// back-to-back, gapped input, resets mid-frame/readout.
module tb_deinterleaver;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_sof;
  logic       out_eof;
  logic [1:0] bank_full;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int last_cyc   = 0;
  int first_cyc  = 0;
  int rises      = 0;
  int conflicts  = 0;
  int n_before   = 0;
  logic prev_v   = 1'b0;

  logic [7:0] oq_d[$];
  logic       oq_s[$];
  logic       oq_e[$];

  deinterleaver dut (
    .clk_out125M (clk),
    .sys_rst_n   (rst_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_sof     (out_sof),
    .out_eof     (out_eof),
    .bank_full   (bank_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid) begin
      if (!prev_v) begin
        rises++;
        if (rises == 1) first_cyc = cyc;
      end
      oq_d.push_back(out_data);
      oq_s.push_back(out_sof);
      oq_e.push_back(out_eof);
    end
    prev_v = out_valid;
    if (in_valid && bank_full == 2'b11) conflicts++;
  end

  function automatic int amap(input int n);
    int d1, d2, d3, d4;
    d1 = n % 4;
    d2 = (n / 4) % 3;
    d3 = (n / 12) % 5;
    d4 = n / 60;
    return 255 * d1 + 85 * d2 + 17 * d3 + d4;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, expv);
    end
  endtask

  task automatic clear_mon();
    oq_d.delete();
    oq_s.delete();
    oq_e.delete();
    rises     = 0;
    conflicts = 0;
  endtask

  task automatic do_reset(input string tag);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk({tag, ".rst_data"}, 32'(out_data), 0);
    chk({tag, ".rst_valid"}, 32'(out_valid), 0);
    chk({tag, ".rst_sof"}, 32'(out_sof), 0);
    chk({tag, ".rst_eof"}, 32'(out_eof), 0);
    chk({tag, ".rst_full"}, 32'(bank_full), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    clear_mon();
  endtask

  task automatic send(input int cnt, input int gap);
    for (int n = 0; n < cnt; n++) begin
      in_data  = 8'(amap(n));
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      last_cyc = cyc;
      in_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int target, input int budget);
    int k;
    k = 0;
    while (oq_d.size() < target && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input int nfr);
    int derr, serr, eerr;
    derr = 0;
    serr = 0;
    eerr = 0;
    chk({tag, ".count"}, 32'(oq_d.size()), 32'(nfr * 1020));
    for (int i = 0; i < oq_d.size(); i++) begin
      if (oq_d[i] !== 8'(i % 1020)) derr++;
      if (oq_s[i] !== ((i % 1020) == 0)) serr++;
      if (oq_e[i] !== ((i % 1020) == 1019)) eerr++;
    end
    chk({tag, ".data_errs"}, 32'(derr), 0);
    chk({tag, ".sof_errs"}, 32'(serr), 0);
    chk({tag, ".eof_errs"}, 32'(eerr), 0);
    chk({tag, ".contig"}, 32'(rises), 1);
    chk({tag, ".idle_valid"}, 32'(out_valid), 0);
    chk({tag, ".idle_full"}, 32'(bank_full), 0);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;

    // 1+2: map check and latency, continuous input
    do_reset("s1");
    send(1020, 0);
    wait_out(1020, 1200);
    settle(10);
    check_out("s1", 1);
    chk("s2.latency", 32'(first_cyc - last_cyc), 3);
    if (oq_d.size() >= 1020) begin
      chk("s1.spot255", 32'(oq_d[255]), 255);
      chk("s1.spot256", 32'(oq_d[256]), 0);
      chk("s1.spot1019", 32'(oq_d[1019]), 251);
    end else begin
      chk("s1.short", 32'(oq_d.size()), 1020);
    end

    // 3: three frames back-to-back
    do_reset("s3");
    send(1020, 0);
    send(1020, 0);
    send(1020, 0);
    wait_out(3060, 2400);
    settle(10);
    check_out("s3", 3);
    chk("s3.conflicts", 32'(conflicts), 0);

    // 4: 1-of-3 duty input
    do_reset("s4");
    send(1020, 2);
    wait_out(1020, 1200);
    settle(10);
    check_out("s4", 1);
    chk("s4.latency", 32'(first_cyc - last_cyc), 3);

    // 5: reset after 500 symbols, then a fresh frame
    do_reset("s5a");
    send(500, 0);
    rst_n = 1'b0;
    #1;
    chk("s5.mid_valid", 32'(out_valid), 0);
    chk("s5.mid_full", 32'(bank_full), 0);
    settle(3);
    chk("s5.mid_data", 32'(out_data), 0);
    rst_n = 1'b1;
    settle(1);
    clear_mon();
    send(1020, 0);
    wait_out(1020, 1200);
    settle(10);
    check_out("s5", 1);

    // 6: reset during readout near r = 600
    do_reset("s6");
    send(1020, 0);
    wait_out(598, 800);
    chk("s6.reached", 32'(oq_d.size()), 598);
    rst_n = 1'b0;
    #1;
    chk("s6.drop_valid", 32'(out_valid), 0);
    chk("s6.drop_full", 32'(bank_full), 0);
    chk("s6.drop_data", 32'(out_data), 0);
    settle(2);
    n_before = oq_d.size();
    rst_n = 1'b1;
    settle(1100);
    chk("s6.residual", 32'(oq_d.size()), 32'(n_before));
    chk("s6.rises", 32'(rises), 1);
    chk("s6.end_full", 32'(bank_full), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
